pll_reset_sequencer: RTL and testbench

//   Downstream of the clock-generation PLL. Runs on the free-running 25 MHz reference clock.

---
 rtl/pll_reset_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// pll_reset_sequencer
//
// Purpose:
//   This block sits downstream of the clock-generation PLL and runs on the
//   free-running 25 MHz reference clock. It synchronizes the asynchronous
//   pll_locked flag and qualifies it. It then releases the per-domain resets
//   (system, ethernet, rgmii, iodelay) in a fixed LSB-first order.
//   If lock never arrives, it pulses pll_reset to retry the PLL. It also
//   counts lock losses and lock timeouts in saturating counters.
//   Each stage_rst_n bit is asynchronous to its target domain, and the
//   consuming domain must re-synchronize it.
//
// Ports:
//   clk_25mhz        in   1           free-running reference clock
//   rst_n            in   1           asynchronous active-low reset
//   pll_locked       in   1           PLL lock flag, asynchronous to clk_25mhz
//   pll_reset        out  1           active-high reset pulse to the PLL
//   stage_rst_n      out  NUM_STAGES  active-low domain resets, bit 0 released first
//   all_released     out  1           high while every stage is released (RUN)
//   lock_loss_count  out  CNT_WIDTH   lock drops seen in RELEASE/RUN, saturating
//   timeout_count    out  CNT_WIDTH   lock-timeout expiries, saturating
//   state            out  3           current FSM state encoding (debug)
// ============================================================================
module pll_reset_sequencer #(
    parameter int NUM_STAGES         = 4,
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY        = 16,
    parameter int LOCK_TIMEOUT       = 262144,
    parameter int PLL_RST_CYCLES     = 32,
    parameter int CNT_WIDTH          = 8
) (
    input  logic                  clk_25mhz,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    output logic                  pll_reset,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  all_released,
    output logic [CNT_WIDTH-1:0]  lock_loss_count,
    output logic [CNT_WIDTH-1:0]  timeout_count,
    output logic [2:0]            state
);

    // The shared timer only ever counts up to one of these terminal values.
    localparam int TIMER_MAX_A = (LOCK_TIMEOUT > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT : LOCK_STABLE_CYCLES;
    localparam int TIMER_MAX_B = (STAGE_DELAY > PLL_RST_CYCLES) ? STAGE_DELAY : PLL_RST_CYCLES;
    localparam int TIMER_MAX   = (TIMER_MAX_A > TIMER_MAX_B) ? TIMER_MAX_A : TIMER_MAX_B;
    localparam int TIMER_W     = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DELAY_LAST   = TIMER_W'(STAGE_DELAY - 1);
    localparam logic [TIMER_W-1:0] PLL_RST_LAST = TIMER_W'(PLL_RST_CYCLES - 1);

    // Thermometer value with only the first domain released.
    localparam logic [NUM_STAGES-1:0] FIRST_STAGE = NUM_STAGES'(1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    state_t                  state_r;
    logic [SYNC_STAGES-1:0]  sync_r;
    logic [TIMER_W-1:0]      timer_r;
    logic                    pll_reset_r;
    logic [NUM_STAGES-1:0]   stage_rst_r;
    logic                    all_released_r;
    logic [CNT_WIDTH-1:0]    lock_loss_cnt_r;
    logic [CNT_WIDTH-1:0]    timeout_cnt_r;

    logic                    locked_s;
    logic [TIMER_W-1:0]      timer_inc_s;
    logic [NUM_STAGES-1:0]   next_thermo_s;

    // Saturating increment: an event counter sticks at all-ones and never wraps.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        if (value == {CNT_WIDTH{1'b1}}) begin
            sat_inc = value;
        end else begin
            sat_inc = value + CNT_WIDTH'(1);
        end
    endfunction

    // Synchronizer chain that brings pll_locked into the reference clock domain.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync_r[SYNC_STAGES-1];

    // Next timer value and next thermometer step (one more domain released).
    always_comb begin
        timer_inc_s   = timer_r + TIMER_W'(1);
        next_thermo_s = (stage_rst_r << 1'b1) | FIRST_STAGE;
    end

    // Sequencer FSM: the state, the shared timer and all registered outputs.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_WAIT_LOCK;
            timer_r         <= '0;
            pll_reset_r     <= 1'b0;
            stage_rst_r     <= '0;
            all_released_r  <= 1'b0;
            lock_loss_cnt_r <= '0;
            timeout_cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_r <= ST_STABLE;
                        timer_r <= '0;
                    end else if (timer_r == TIMEOUT_LAST) begin
                        state_r       <= ST_PLL_RST;
                        timer_r       <= '0;
                        pll_reset_r   <= 1'b1;
                        timeout_cnt_r <= sat_inc(timeout_cnt_r);
                    end else begin
                        timer_r <= timer_inc_s;
                    end
                end

                // Lock status is ignored here, because the PLL is being held in reset.
                ST_PLL_RST: begin
                    if (timer_r == PLL_RST_LAST) begin
                        state_r     <= ST_WAIT_LOCK;
                        timer_r     <= '0;
                        pll_reset_r <= 1'b0;
                    end else begin
                        timer_r <= timer_inc_s;
                    end
                end

                // A drop here counts as a glitch during qualification, not as a lock loss.
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_r <= ST_WAIT_LOCK;
                        timer_r <= '0;
                    end else if (timer_r == STABLE_LAST) begin
                        timer_r     <= '0;
                        stage_rst_r <= FIRST_STAGE;
                        if (FIRST_STAGE[NUM_STAGES-1]) begin
                            state_r        <= ST_RUN;
                            all_released_r <= 1'b1;
                        end else begin
                            state_r <= ST_RELEASE;
                        end
                    end else begin
                        timer_r <= timer_inc_s;
                    end
                end

                ST_RELEASE: begin
                    if (!locked_s) begin
                        state_r         <= ST_WAIT_LOCK;
                        timer_r         <= '0;
                        stage_rst_r     <= '0;
                        all_released_r  <= 1'b0;
                        lock_loss_cnt_r <= sat_inc(lock_loss_cnt_r);
                    end else if (timer_r == DELAY_LAST) begin
                        timer_r     <= '0;
                        stage_rst_r <= next_thermo_s;
                        if (next_thermo_s[NUM_STAGES-1]) begin
                            state_r        <= ST_RUN;
                            all_released_r <= 1'b1;
                        end else begin
                            state_r <= ST_RELEASE;
                        end
                    end else begin
                        timer_r <= timer_inc_s;
                    end
                end

                ST_RUN: begin
                    if (!locked_s) begin
                        state_r         <= ST_WAIT_LOCK;
                        timer_r         <= '0;
                        stage_rst_r     <= '0;
                        all_released_r  <= 1'b0;
                        lock_loss_cnt_r <= sat_inc(lock_loss_cnt_r);
                    end else begin
                        state_r <= ST_RUN;
                    end
                end

                // An illegal encoding falls back to a safe state with all domains held in reset.
                default: begin
                    state_r        <= ST_WAIT_LOCK;
                    timer_r        <= '0;
                    pll_reset_r    <= 1'b0;
                    stage_rst_r    <= '0;
                    all_released_r <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset       = pll_reset_r;
    assign stage_rst_n     = stage_rst_r;
    assign all_released    = all_released_r;
    assign lock_loss_count = lock_loss_cnt_r;
    assign timeout_count   = timeout_cnt_r;
    assign state           = state_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ============================================================================
// tb_pll_reset_sequencer
//
// Purpose:
//   This bench drives pll_locked once per cycle on the falling edge.
//   For each drive, a time-stamp reference model predicts the DUT outputs
//   after the following rising edge and pushes that prediction into a queue.
//   A separate monitor pops each prediction one time step after the rising
//   edge and compares it with the DUT.
//   The stimulus starts with directed segments (bring-up, glitch, drops,
//   timeouts and a mid-run reset). It continues with random segments, and
//   ends with a long loss of lock that saturates the timeout counter.
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int N   = 4;
    localparam int SS  = 2;
    localparam int LSC = 8;
    localparam int SD  = 4;
    localparam int TO  = 64;
    localparam int PRC = 4;
    localparam int CW  = 8;

    logic          clk_25mhz = 1'b0;
    logic          rst_n     = 1'b0;
    logic          pll_locked = 1'b0;
    logic          pll_reset;
    logic [N-1:0]  stage_rst_n;
    logic          all_released;
    logic [CW-1:0] lock_loss_count;
    logic [CW-1:0] timeout_count;
    logic [2:0]    state;

    pll_reset_sequencer #(
        .NUM_STAGES        (N),
        .SYNC_STAGES       (SS),
        .LOCK_STABLE_CYCLES(LSC),
        .STAGE_DELAY       (SD),
        .LOCK_TIMEOUT      (TO),
        .PLL_RST_CYCLES    (PRC),
        .CNT_WIDTH         (CW)
    ) dut (
        .clk_25mhz      (clk_25mhz),
        .rst_n          (rst_n),
        .pll_locked     (pll_locked),
        .pll_reset      (pll_reset),
        .stage_rst_n    (stage_rst_n),
        .all_released   (all_released),
        .lock_loss_count(lock_loss_count),
        .timeout_count  (timeout_count),
        .state          (state)
    );

    always #5 clk_25mhz = ~clk_25mhz;

    // The output snapshot is {pll_reset, stage_rst_n, all_released, lock_loss, timeout, state}.
    typedef logic [24:0] snap_t;
    localparam snap_t RESET_SNAP = 25'd0;

    snap_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model. It records the edge index at which the current mode
    // was entered and derives every output from the elapsed edges.
    localparam int M_WAIT = 0;
    localparam int M_PRST = 1;
    localparam int M_QUAL = 2;
    localparam int M_UP   = 3;

    int   m_mode;
    int   m_start;
    int   m_e;
    logic m_s0;
    logic m_s1;
    int   m_llc;
    int   m_tcnt;

    function automatic snap_t dut_snap();
        return {pll_reset, stage_rst_n, all_released, lock_loss_count, timeout_count, state};
    endfunction

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic check(input string name, input snap_t act, input snap_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got prst=%0b stg=%b all=%0b loss=%0d tmo=%0d st=%0d, want prst=%0b stg=%b all=%0b loss=%0d tmo=%0d st=%0d",
                     name, $time, act[24], act[23:20], act[19], act[18:11], act[10:3], act[2:0],
                     exp[24], exp[23:20], exp[19], exp[18:11], exp[10:3], exp[2:0]);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_WAIT;
        m_start = 0;
        m_e     = 0;
        m_s0    = 1'b0;
        m_s1    = 1'b0;
        m_llc   = 0;
        m_tcnt  = 0;
    endtask

    // Advance the model by one rising edge, with lvl as the level sampled at that edge.
    task automatic model_edge(input logic lvl, output snap_t exp);
        logic       ls;
        int         stages;
        logic [3:0] thermo;
        logic [2:0] st;
        // The FSM sees the level that was sampled two edges earlier.
        ls   = m_s1;
        m_s1 = m_s0;
        m_s0 = lvl;
        m_e++;
        case (m_mode)
            M_WAIT: begin
                if (ls) begin
                    m_mode = M_QUAL; m_start = m_e;
                end else if (m_e - m_start == TO) begin
                    m_mode = M_PRST; m_start = m_e; m_tcnt = sat(m_tcnt);
                end
            end
            M_PRST: begin
                if (m_e - m_start == PRC) begin
                    m_mode = M_WAIT; m_start = m_e;
                end
            end
            M_QUAL: begin
                if (!ls) begin
                    m_mode = M_WAIT; m_start = m_e;
                end else if (m_e - m_start == LSC) begin
                    m_mode = M_UP; m_start = m_e;
                end
            end
            default: begin
                if (!ls) begin
                    m_mode = M_WAIT; m_start = m_e; m_llc = sat(m_llc);
                end
            end
        endcase
        stages = 0;
        if (m_mode == M_UP) begin
            stages = 1 + (m_e - m_start) / SD;
            if (stages > N) stages = N;
        end
        thermo = 4'((1 << stages) - 1);
        case (m_mode)
            M_WAIT:  st = 3'd0;
            M_PRST:  st = 3'd1;
            M_QUAL:  st = 3'd2;
            default: st = (stages == N) ? 3'd4 : 3'd3;
        endcase
        exp = {(m_mode == M_PRST), thermo, (stages == N), 8'(m_llc), 8'(m_tcnt), st};
    endtask

    // One cycle of stimulus: drive on the falling edge and queue the prediction for the next rising edge.
    task automatic step(input logic lvl);
        snap_t e;
        @(negedge clk_25mhz);
        pll_locked = lvl;
        model_edge(lvl, e);
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl);
    endtask

    // Pulse rst_n inside one low clock phase and check the asynchronous reset values.
    task automatic reset_step();
        snap_t e;
        @(negedge clk_25mhz);
        pll_locked = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("async_reset", dut_snap(), RESET_SNAP);
        #1 rst_n = 1'b1;
        model_reset();
        model_edge(1'b0, e);
        exp_q.push_back(e);
    endtask

    // Monitor: compare the DUT against each queued prediction just after the rising edge.
    always @(posedge clk_25mhz) begin
        snap_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle", dut_snap(), e);
        end
    end

    initial begin
        reset_step();
        // Clean bring-up into RUN.
        hold(1'b1, 30);
        // Lock drop in RUN, then re-lock.
        hold(1'b0, 1);
        hold(1'b1, 40);
        // Glitch during qualification.
        hold(1'b0, 10);
        hold(1'b1, 5);
        hold(1'b0, 3);
        hold(1'b1, 40);
        // Drop while only part of the stages is released.
        hold(1'b0, 5);
        hold(1'b1, 15);
        hold(1'b0, 3);
        // Repeated timeouts and PLL reset pulses.
        hold(1'b0, 300);
        // Bring up to RUN, then reset asynchronously in the middle of operation.
        hold(1'b1, 40);
        reset_step();
        hold(1'b1, 30);
        // Random lock behaviour.
        for (int s = 0; s < 500; s++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = lvl ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 20));
            hold(lvl, len);
        end
        // A long loss of lock saturates the timeout counter.
        hold(1'b0, 18000);
        hold(1'b1, 40);
        @(posedge clk_25mhz);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
